// File: rtl/cache_block.sv
`default_nettype none
// ============================================================================
// Module      : cache_block
// Description : One cache line holding WORDS data words plus tag, valid and
//               dirty state. Serves one request per clock (raw read, fill,
//               compare read, compare write) with registered results that
//               are qualified by a one-cycle ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_block #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 5,
    parameter int WORDS      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              write,
    input  logic                              compare,
    input  logic [$clog2(WORDS)-1:0]          word,
    input  logic [TAG_WIDTH-1:0]              tag_in,
    input  logic                              valid_in,
    input  logic [0:DATA_WIDTH-1]             data_in,
    output logic [0:DATA_WIDTH-1]             data_out,
    output logic [TAG_WIDTH-1:0]              tag_out,
    output logic                              valid_out,
    output logic                              dirty_out,
    output logic                              hit,
    output logic                              ack
);

    // Line storage and status
    logic [0:DATA_WIDTH-1] words_q [WORDS];
    logic [0:DATA_WIDTH-1] words_d [WORDS];
    logic [TAG_WIDTH-1:0]  tag_q,   tag_d;
    logic                  valid_q, valid_d;
    logic                  dirty_q, dirty_d;

    // Registered request results
    logic [0:DATA_WIDTH-1] data_out_q, data_out_d;
    logic                  hit_q,      hit_d;
    logic                  ack_q,      ack_d;

    // Tag match is only meaningful for a valid line
    logic                  match;

    assign match = valid_q && (tag_q == tag_in);

    // Decode the request and compute the next line state and results
    always_comb begin
        words_d    = words_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        data_out_d = data_out_q;
        hit_d      = hit_q;
        ack_d      = 1'b0;

        if (enable) begin
            ack_d = 1'b1;
            case ({compare, write})
                2'b00: begin
                    // Raw read for write-back / eviction
                    data_out_d = words_q[word];
                    hit_d      = 1'b0;
                end
                2'b01: begin
                    // Fill: installs a new tag and always leaves the line clean
                    words_d[word] = data_in;
                    tag_d         = tag_in;
                    valid_d       = valid_in;
                    dirty_d       = 1'b0;
                    hit_d         = 1'b0;
                    data_out_d    = data_in;
                end
                2'b10: begin
                    // Compare read returns the word whether or not it hits
                    hit_d      = match;
                    data_out_d = words_q[word];
                end
                default: begin
                    // Compare write only modifies the line on a hit
                    hit_d = match;
                    if (match) begin
                        words_d[word] = data_in;
                        dirty_d       = 1'b1;
                        data_out_d    = data_in;
                    end
                end
            endcase
        end
    end

    // State and result registers; reset wins over any request
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                words_q[i] <= '0;
            end
            tag_q      <= '0;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
            data_out_q <= '0;
            hit_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                words_q[i] <= words_d[i];
            end
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            data_out_q <= data_out_d;
            hit_q      <= hit_d;
            ack_q      <= ack_d;
        end
    end

    assign data_out  = data_out_q;
    assign tag_out   = tag_q;
    assign valid_out = valid_q;
    assign dirty_out = dirty_q;
    assign hit       = hit_q;
    assign ack       = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_block
// Description : Self-checking bench for cache_block. Directed scenarios plus
//               randomized requests, compared every cycle against a
//               behavioural model of the cache line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_block;

    localparam int DATA_WIDTH = 16;
    localparam int TAG_WIDTH  = 5;
    localparam int WORDS      = 4;

    logic                  clk;
    logic                  rst;
    logic                  enable;
    logic                  write;
    logic                  compare;
    logic [1:0]            word;
    logic [TAG_WIDTH-1:0]  tag_in;
    logic                  valid_in;
    logic [0:DATA_WIDTH-1] data_in;
    logic [0:DATA_WIDTH-1] data_out;
    logic [TAG_WIDTH-1:0]  tag_out;
    logic                  valid_out;
    logic                  dirty_out;
    logic                  hit;
    logic                  ack;

    cache_block #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .WORDS      (WORDS)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .write     (write),
        .compare   (compare),
        .word      (word),
        .tag_in    (tag_in),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .tag_out   (tag_out),
        .valid_out (valid_out),
        .dirty_out (dirty_out),
        .hit       (hit),
        .ack       (ack)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Behavioural model of the line
    logic [15:0] m_mem [WORDS];
    logic [4:0]  m_tag;
    logic        m_valid;
    logic        m_dirty;
    logic [15:0] e_data;
    logic        e_hit;
    logic        e_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the request the DUT sees at an edge to the model
    task automatic model_edge(input logic rs, input logic en, input logic wr,
                              input logic cmp, input logic [1:0] wd,
                              input logic [4:0] tg, input logic vi,
                              input logic [15:0] di);
        logic m;
        if (rs) begin
            for (int i = 0; i < WORDS; i++) m_mem[i] = 16'h0;
            m_tag = '0; m_valid = 0; m_dirty = 0;
            e_data = 16'h0; e_hit = 0; e_ack = 0;
        end else if (!en) begin
            e_ack = 0;
        end else begin
            e_ack = 1;
            m = m_valid && (m_tag == tg);
            if (!cmp) begin
                e_hit = 0;
                if (wr) begin
                    m_mem[wd] = di; m_tag = tg; m_valid = vi; m_dirty = 0;
                    e_data = di;
                end else begin
                    e_data = m_mem[wd];
                end
            end else begin
                e_hit = m;
                if (!wr) begin
                    e_data = m_mem[wd];
                end else if (m) begin
                    m_mem[wd] = di; m_dirty = 1; e_data = di;
                end
            end
        end
    endtask

    // Drive one request for one edge, then check every output against the model
    task automatic cyc(input logic rs, input logic en, input logic wr,
                       input logic cmp, input logic [1:0] wd,
                       input logic [4:0] tg, input logic vi,
                       input logic [15:0] di);
        @(negedge clk);
        rst = rs; enable = en; write = wr; compare = cmp;
        word = wd; tag_in = tg; valid_in = vi; data_in = di;
        @(posedge clk);
        model_edge(rs, en, wr, cmp, wd, tg, vi, di);
        #1;
        check("data_out",  32'(data_out),  32'(e_data));
        check("tag_out",   32'(tag_out),   32'(m_tag));
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("dirty_out", 32'(dirty_out), 32'(m_dirty));
        check("hit",       32'(hit),       32'(e_hit));
        check("ack",       32'(ack),       32'(e_ack));
    endtask

    logic [4:0] tsel;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1; enable = 0; write = 0; compare = 0;
        word = 0; tag_in = 0; valid_in = 0; data_in = 0;
        for (int i = 0; i < WORDS; i++) m_mem[i] = 16'h0;
        m_tag = 0; m_valid = 0; m_dirty = 0; e_data = 0; e_hit = 0; e_ack = 0;

        // Reset, then raw read of word 0
        cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 0, 0, 0, 16'h0);
        check("rst_rd_ack",  32'(ack), 32'd1);
        check("rst_rd_data", 32'(data_out), 32'h0);

        // Fill word 2, read it back and the untouched neighbours
        cyc(0, 1, 1, 0, 2, 5'h0A, 1, 16'h0F0F);
        cyc(0, 1, 0, 0, 2, 5'h00, 0, 16'h0);
        check("fill_rd", 32'(data_out), 32'h0F0F);
        check("fill_tag", 32'(tag_out), 32'h0A);
        cyc(0, 1, 0, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 1, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 3, 0, 0, 16'h0);

        // Compare reads: hit then miss
        cyc(0, 1, 0, 1, 2, 5'h0A, 0, 16'h0);
        check("cmp_rd_hit", 32'(hit), 32'd1);
        cyc(0, 1, 0, 1, 2, 5'h0B, 0, 16'h0);
        check("cmp_rd_miss", 32'(hit), 32'd0);

        // Compare writes: hit sets dirty, miss leaves the word alone
        cyc(0, 1, 1, 1, 1, 5'h0A, 0, 16'h1234);
        check("cmp_wr_dirty", 32'(dirty_out), 32'd1);
        cyc(0, 1, 1, 1, 1, 5'h0B, 0, 16'hDEAD);
        cyc(0, 1, 0, 0, 1, 0, 0, 16'h0);
        check("cmp_wr_keep", 32'(data_out), 32'h1234);

        // Idle cycle drops ack and holds outputs
        cyc(0, 0, 1, 0, 1, 5'h1F, 1, 16'hFFFF);

        // Fill with valid_in=0: equal tags must not hit
        cyc(0, 1, 1, 0, 0, 5'h0C, 0, 16'hAAAA);
        cyc(0, 1, 0, 1, 0, 5'h0C, 0, 16'h0);
        check("invalid_no_hit", 32'(hit), 32'd0);

        // Short enable pulse between edges has no effect
        @(negedge clk);
        enable = 1; write = 1; compare = 0; word = 3; data_in = 16'h5555;
        #2 enable = 0;
        @(posedge clk);
        model_edge(0, 0, 1, 0, 3, 0, 0, 16'h0);
        #1 check("glitch_ack", 32'(ack), 32'd0);
        cyc(0, 1, 0, 0, 3, 0, 0, 16'h0);

        // Reset together with a write request
        cyc(1, 1, 1, 0, 0, 5'h11, 1, 16'hBEEF);
        check("rst_wr_ack", 32'(ack), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 16'h0);

        // Randomized traffic; tags biased toward a few values so hits occur
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: tsel = 5'h0A;
                1: tsel = 5'h0B;
                2: tsel = m_tag;
                default: tsel = 5'($urandom);
            endcase
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                1'($urandom), 1'($urandom), 2'($urandom), tsel,
                ($urandom_range(0, 3) != 0), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
